dmem_lsu: RTL
=============

# dmem_lsu

Load/store unit sitting between the datapath's memory stage and the data memory. It takes one load or store request at a time: byte address, RISC-V funct3 width code, store data. It drives the data memory's word-addressed bus (`d_mem_addr`, `d_mem_we`, bidirectional `d_mem_data`). It performs sub-word extraction with sign/zero extension, and does a read-modify-write for byte, half and word stores into the doubleword-wide memory.

## Interface
- `SIZE`, 64, data width; doubleword = 8 bytes.
- `addr_width`, 6, data memory word-index width.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 1: request strobe. Sampled only when `busy`=0.
- `store` in 1: 1 = store, 0 = load.
- `funct3` in 3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu. 111, and any 1xx with `store`=1, is illegal.
- `addr` in 64: byte address.
- `wdata` in SIZE: store data, right-aligned.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: valid with `done`. High for a misaligned access or illegal `funct3`.
- `rdata` out SIZE: load result. Held until the next `done`.
- `d_mem_addr` out addr_width: memory word index = `addr[addr_width+2:3]`. Upper address bits are ignored, so addresses wrap.
- `d_mem_we` out 1: memory write enable.
- `d_mem_data` inout SIZE: driven by this block only while `d_mem_we`=1, otherwise high-Z.

## Operation
- IDLE: when `req`=1, latch `store`, `funct3`, `addr`, `wdata`. Then check the request:
  - Misaligned: h with `addr[0]`≠0, w with `addr[1:0]`≠0, d with `addr[2:0]`≠0.
  - Misaligned or illegal goes to DONE with fault set. No memory access.
  - Legal load or legal sub-word store goes to RD.
  - Legal doubleword store goes to WR.
- RD: drive `d_mem_addr`, `d_mem_we`=0. Capture `d_mem_data` into the word buffer at the clock edge.
  - Load: go to DONE.
  - Store: go to WR.
- Byte offset: `off` = `addr[2:0]`.
- Load extraction: take the lane at byte `off` from the word buffer.
  - b, h, w: sign-extend to SIZE.
  - bu, hu, wu: zero-extend.
  - d: whole word.
- WR: `d_mem_we`=1. Drive `d_mem_data` with the merged word, which memory writes at the end of this cycle. Then go to DONE.
  - Merged word = word buffer with the b/h/w lane at `off` replaced by low bits of `wdata`.
  - For d, merged word = `wdata`.
- DONE: `done`=1 for one cycle. `fault` reflects the check. `rdata` updates only for non-faulting loads. Then go to IDLE.
- `req` while `busy`=1 is ignored; no queueing.

## Timing
- Cycle 0 = the edge where `req` is sampled.
- `done` asserts in:
  - cycle 1: fault;
  - cycle 2: load, doubleword store;
  - cycle 3: sub-word store.
- Back-to-back: a new `req` is accepted in the cycle after `done`, when IDLE is re-entered.
- Reset values:
  - state IDLE;
  - `busy`, `done`, `fault`, `d_mem_we` = 0;
  - `rdata` = 0, `d_mem_addr` = 0;
  - `d_mem_data` high-Z.
- `d_mem_we` is gated with `~rst`. A `rst` asserted during WR suppresses the memory write that cycle, and the unit is IDLE next cycle with no `done`.
- Reset during RD: no `done`, `rdata` cleared.
- Outside RD/WR, `d_mem_addr` holds the last index. `d_mem_we`=0 in every state except WR.

## Test plan
- Preload mem[16]=731 (0x2DB). Load d at addr 128: `done` in cycle 2, `rdata`=731, `fault`=0.
- Load b at 128 → `rdata`=0xFFFF_FFFF_FFFF_FFDB. Load bu at 128 → 0xDB. Load hu at 128 → 0x02DB.
- Store b, `wdata`=0xAA, addr 129: RD then WR, `done` in cycle 3. mem[16] = 0x0000_0000_0000_AADB. A following load d at 128 → same value.
- Store d, `wdata`=0x1234_5678_9ABC_DEF0, addr 168: `d_mem_addr`=21, `d_mem_we` high for exactly one cycle. mem[21] updated; `done` in cycle 2.
- Load w at 130 (misaligned) and `funct3`=111: each gives `done`+`fault` in cycle 1. `d_mem_we` never asserts; `rdata` unchanged.
- Store h at 240 with `rst` asserted during WR: mem[30] stays 1000, no `done`, all outputs at reset values. `req` retried after reset completes normally.

Source files
------------

// File: rtl/dmem_lsu.sv
// Load/store unit: one request at a time; done after 1 (fault), 2 (load, d store) or 3 (sub-word store) cycles.
// No queueing: req is only looked at while idle, anything presented while busy is dropped.
module dmem_lsu #(
    parameter int SIZE       = 64,
    parameter int addr_width = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  store,
    input  logic [2:0]            funct3,
    input  logic [63:0]           addr,
    input  logic [SIZE-1:0]       wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic [SIZE-1:0]       rdata,
    output logic [addr_width-1:0] d_mem_addr,
    output logic                  d_mem_we,
    inout  wire  [SIZE-1:0]       d_mem_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic            store_q;
    logic [2:0]      f3_q;
    logic [2:0]      off_q;
    logic [SIZE-1:0] wdata_q;
    logic [SIZE-1:0] word_q;
    logic            fault_q;

    logic            illegal;
    logic            misaligned;
    logic            bad_req;
    logic [5:0]      sh;
    logic [SIZE-1:0] lane_mask;
    logic [SIZE-1:0] merged;

    // Upper address bits select nothing; addresses simply wrap.
    logic unused_addr;
    assign unused_addr = ^addr[63:addr_width+3];

    function automatic logic [SIZE-1:0] extract(input logic [SIZE-1:0] w,
                                                input logic [2:0]      f3,
                                                input logic [2:0]      off);
        logic [SIZE-1:0] s;
        s = w >> {off, 3'b000};
        case (f3)
            3'b000:  extract = {{(SIZE-8){s[7]}}, s[7:0]};
            3'b001:  extract = {{(SIZE-16){s[15]}}, s[15:0]};
            3'b010:  extract = {{(SIZE-32){s[31]}}, s[31:0]};
            3'b100:  extract = {{(SIZE-8){1'b0}}, s[7:0]};
            3'b101:  extract = {{(SIZE-16){1'b0}}, s[15:0]};
            3'b110:  extract = {{(SIZE-32){1'b0}}, s[31:0]};
            default: extract = w;
        endcase
    endfunction

    // Alignment is judged on the access size alone, so bu/hu/wu follow b/h/w.
    always_comb begin
        illegal    = (funct3 == 3'b111) || (store && funct3[2]);
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            2'b11:   misaligned = (addr[2:0] != 3'b000);
            default: misaligned = 1'b0;
        endcase
        bad_req = illegal || misaligned;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (bad_req) begin
                        state_d = DONE;
                    end else if (store && (funct3[1:0] == 2'b11)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:      state_d = store_q ? WR : DONE;
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            store_q    <= 1'b0;
            f3_q       <= 3'b000;
            off_q      <= 3'b000;
            wdata_q    <= '0;
            word_q     <= '0;
            fault_q    <= 1'b0;
            rdata      <= '0;
            d_mem_addr <= '0;
        end else begin
            if (state_q == IDLE && req) begin
                store_q <= store;
                f3_q    <= funct3;
                off_q   <= addr[2:0];
                wdata_q <= wdata;
                fault_q <= bad_req;
                if (!bad_req) begin
                    d_mem_addr <= addr[addr_width+2:3];
                end
            end
            // Load result goes straight into rdata so it is valid alongside done.
            if (state_q == RD) begin
                word_q <= d_mem_data;
                if (!store_q) begin
                    rdata <= extract(d_mem_data, f3_q, off_q);
                end
            end
        end
    end

    always_comb begin
        sh        = {off_q, 3'b000};
        lane_mask = '0;
        case (f3_q[1:0])
            2'b00:   lane_mask[7:0]  = '1;
            2'b01:   lane_mask[15:0] = '1;
            2'b10:   lane_mask[31:0] = '1;
            default: lane_mask       = '1;
        endcase
        if (f3_q[1:0] == 2'b11) begin
            merged = wdata_q;
        end else begin
            merged = (word_q & ~(lane_mask << sh)) | ((wdata_q << sh) & (lane_mask << sh));
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign fault      = done && fault_q;
    assign d_mem_we   = (state_q == WR) && !rst;
    assign d_mem_data = d_mem_we ? merged : 'z;

endmodule
